// File: rtl/clock_pkg.sv
// clock_pkg: constants and types shared by the digital clock stages
// (keypad entry, time-of-day counter, display driver).
//   CLK_HZ_DEFAULT        default system clock frequency in Hz
//   SEC_TENS_MAX          largest tens digit of minutes/seconds (5)
//   DIG_MAX               largest BCD units digit (9)
//   HOUR_TENS_MAX         largest hour tens digit (2)
//   HOUR_UNITS_MAX_AT_20  largest hour units digit when the tens digit is 2 (3)
//   bcd_t                 one 4-bit BCD digit
package clock_pkg;

  localparam int unsigned CLK_HZ_DEFAULT = 50_000_000;

  localparam logic [3:0] SEC_TENS_MAX         = 4'd5;
  localparam logic [3:0] DIG_MAX              = 4'd9;
  localparam logic [3:0] HOUR_TENS_MAX        = 4'd2;
  localparam logic [3:0] HOUR_UNITS_MAX_AT_20 = 4'd3;

  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides the system clock down to a once-per-period strobe.
// Ports:
//   clk  in   system clock
//   rst  in   synchronous active-high reset (count and tc to 0)
//   clr  in   restart the count from 0 (takes priority over en)
//   en   in   advance the count by one this cycle
//   tc   out  registered; 1 while the count sits at CLK_HZ-1
// tc is registered from the next count value, so it is aligned with the
// cycle in which the count equals its terminal value. The consumer acts
// at the edge ending that cycle, which is also where the count wraps.
module tick_prescaler #(
  parameter int unsigned CLK_HZ = clock_pkg::CLK_HZ_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] TC_VAL = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tc_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == TC_VAL) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= (cnt_d == TC_VAL);
    end
  end

  assign tc = tc_q;

endmodule

// File: rtl/clock_time_counter.sv
// clock_time_counter: 24-hour time-of-day counter with keypad load.
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   set_en               setting mode (level); its 1->0 edge loads set_*
//   set_h1..set_s0       BCD digits from the keypad stage
//   H1,H0,M1,M0,S1,S0    current time, BCD
//   sec_tick             one-cycle pulse, first cycle a new second is visible
//   hour_tick            like sec_tick, but only when M:S wrapped to 00:00
//   load_err             sticky: the last load attempt was rejected
// Priority each cycle: reset, then load (falling set_en), then setting
// mode hold, then run-mode counting.
module clock_time_counter
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ = CLK_HZ_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_en,
  input  logic [3:0] set_h1,
  input  logic [3:0] set_h0,
  input  logic [3:0] set_m1,
  input  logic [3:0] set_m0,
  input  logic [3:0] set_s1,
  input  logic [3:0] set_s0,
  output logic [3:0] H1,
  output logic [3:0] H0,
  output logic [3:0] M1,
  output logic [3:0] M0,
  output logic [3:0] S1,
  output logic [3:0] S0,
  output logic       sec_tick,
  output logic       hour_tick,
  output logic       load_err
);

  bcd_t h1_q, h0_q, m1_q, m0_q, s1_q, s0_q;
  bcd_t h1_d, h0_d, m1_d, m0_d, s1_d, s0_d;
  logic set_en_q;
  logic sec_tick_q, sec_tick_d;
  logic hour_tick_q, hour_tick_d;
  logic load_err_q, load_err_d;

  logic load, run, tc, set_ok;

  // Load fires on the falling edge of set_en; run excludes that cycle so a
  // load can never coincide with an increment.
  assign load = set_en_q & ~set_en;
  assign run  = ~set_en & ~load;

  tick_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (set_en | load),
    .en  (run),
    .tc  (tc)
  );

  assign set_ok = (set_h1 <= HOUR_TENS_MAX) &&
                  (set_h0 <= DIG_MAX) &&
                  !((set_h1 == HOUR_TENS_MAX) && (set_h0 > HOUR_UNITS_MAX_AT_20)) &&
                  (set_m1 <= SEC_TENS_MAX) && (set_m0 <= DIG_MAX) &&
                  (set_s1 <= SEC_TENS_MAX) && (set_s0 <= DIG_MAX);

  // BCD cascade: each carry is the previous carry AND this digit at its max.
  logic c_s0, c_s1, c_m0, c_m1;
  bcd_t s0_inc, s1_inc, m0_inc, m1_inc, h0_inc, h1_inc;

  always_comb begin
    c_s0 = (s0_q == DIG_MAX);
    c_s1 = c_s0 && (s1_q == SEC_TENS_MAX);
    c_m0 = c_s1 && (m0_q == DIG_MAX);
    c_m1 = c_m0 && (m1_q == SEC_TENS_MAX);

    s0_inc = c_s0 ? 4'd0 : s0_q + 4'd1;
    s1_inc = s1_q;
    if (c_s0) s1_inc = (s1_q == SEC_TENS_MAX) ? 4'd0 : s1_q + 4'd1;
    m0_inc = m0_q;
    if (c_s1) m0_inc = (m0_q == DIG_MAX) ? 4'd0 : m0_q + 4'd1;
    m1_inc = m1_q;
    if (c_m0) m1_inc = (m1_q == SEC_TENS_MAX) ? 4'd0 : m1_q + 4'd1;

    h0_inc = h0_q;
    h1_inc = h1_q;
    if (c_m1) begin
      if ((h1_q == HOUR_TENS_MAX) && (h0_q == HOUR_UNITS_MAX_AT_20)) begin
        h0_inc = 4'd0;
        h1_inc = 4'd0;
      end else if (h0_q == DIG_MAX) begin
        h0_inc = 4'd0;
        h1_inc = h1_q + 4'd1;
      end else begin
        h0_inc = h0_q + 4'd1;
      end
    end
  end

  always_comb begin
    h1_d        = h1_q;
    h0_d        = h0_q;
    m1_d        = m1_q;
    m0_d        = m0_q;
    s1_d        = s1_q;
    s0_d        = s0_q;
    load_err_d  = load_err_q;
    sec_tick_d  = 1'b0;
    hour_tick_d = 1'b0;
    if (load) begin
      if (set_ok) begin
        h1_d       = set_h1;
        h0_d       = set_h0;
        m1_d       = set_m1;
        m0_d       = set_m0;
        s1_d       = set_s1;
        s0_d       = set_s0;
        load_err_d = 1'b0;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (run && tc) begin
      h1_d        = h1_inc;
      h0_d        = h0_inc;
      m1_d        = m1_inc;
      m0_d        = m0_inc;
      s1_d        = s1_inc;
      s0_d        = s0_inc;
      sec_tick_d  = 1'b1;
      hour_tick_d = c_m1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h1_q        <= 4'd0;
      h0_q        <= 4'd0;
      m1_q        <= 4'd0;
      m0_q        <= 4'd0;
      s1_q        <= 4'd0;
      s0_q        <= 4'd0;
      set_en_q    <= 1'b0;
      sec_tick_q  <= 1'b0;
      hour_tick_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      h1_q        <= h1_d;
      h0_q        <= h0_d;
      m1_q        <= m1_d;
      m0_q        <= m0_d;
      s1_q        <= s1_d;
      s0_q        <= s0_d;
      set_en_q    <= set_en;
      sec_tick_q  <= sec_tick_d;
      hour_tick_q <= hour_tick_d;
      load_err_q  <= load_err_d;
    end
  end

  assign H1        = h1_q;
  assign H0        = h0_q;
  assign M1        = m1_q;
  assign M0        = m0_q;
  assign S1        = s1_q;
  assign S0        = s0_q;
  assign sec_tick  = sec_tick_q;
  assign hour_tick = hour_tick_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_clock_time_counter.sv
// tb_clock_time_counter: directed bench for clock_time_counter at CLK_HZ=4.
// A seconds-of-day model predicts every output each cycle; literal
// expectations at key points pin the model to hand-computed values.
module tb_clock_time_counter;

  localparam int unsigned HZ = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       set_en;
  logic [3:0] set_h1, set_h0, set_m1, set_m0, set_s1, set_s0;
  logic [3:0] H1, H0, M1, M0, S1, S0;
  logic       sec_tick, hour_tick, load_err;

  int errors = 0;
  int checks = 0;
  logic chk_on = 1'b0;

  clock_time_counter #(.CLK_HZ(HZ)) dut (
    .clk(clk), .rst(rst), .set_en(set_en),
    .set_h1(set_h1), .set_h0(set_h0), .set_m1(set_m1),
    .set_m0(set_m0), .set_s1(set_s1), .set_s0(set_s0),
    .H1(H1), .H0(H0), .M1(M1), .M0(M0), .S1(S1), .S0(S0),
    .sec_tick(sec_tick), .hour_tick(hour_tick), .load_err(load_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int   m_secs = 0;   // seconds since midnight
  int   m_cnt  = 0;   // cycles into the current second
  logic m_seq  = 1'b0;
  logic m_st   = 1'b0;
  logic m_ht   = 1'b0;
  logic m_err  = 1'b0;

  function automatic bit valid_time(input logic [23:0] t);
    int h1, h0, m1, m0, s1, s0;
    h1 = int'(t[23:20]); h0 = int'(t[19:16]); m1 = int'(t[15:12]);
    m0 = int'(t[11:8]);  s1 = int'(t[7:4]);   s0 = int'(t[3:0]);
    if (h1 > 9 || h0 > 9 || m1 > 9 || m0 > 9 || s1 > 9 || s0 > 9) return 1'b0;
    return (h1 * 10 + h0 < 24) && (m1 * 10 + m0 < 60) && (s1 * 10 + s0 < 60);
  endfunction

  function automatic int to_secs(input logic [23:0] t);
    return (int'(t[23:20]) * 10 + int'(t[19:16])) * 3600 +
           (int'(t[15:12]) * 10 + int'(t[11:8])) * 60 +
           int'(t[7:4]) * 10 + int'(t[3:0]);
  endfunction

  function automatic logic [23:0] to_bcd(input int secs);
    int hh, mm, ss;
    hh = secs / 3600;
    mm = (secs / 60) % 60;
    ss = secs % 60;
    return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10),
            4'(ss / 10), 4'(ss % 10)};
  endfunction

  logic [23:0] set_vec;
  assign set_vec = {set_h1, set_h0, set_m1, set_m0, set_s1, set_s0};

  always @(posedge clk) begin
    if (rst) begin
      m_secs <= 0; m_cnt <= 0; m_seq <= 1'b0;
      m_st <= 1'b0; m_ht <= 1'b0; m_err <= 1'b0;
    end else begin
      m_seq <= set_en;
      if (m_seq && !set_en) begin
        m_cnt <= 0; m_st <= 1'b0; m_ht <= 1'b0;
        if (valid_time(set_vec)) begin
          m_secs <= to_secs(set_vec);
          m_err  <= 1'b0;
        end else begin
          m_err  <= 1'b1;
        end
      end else if (set_en) begin
        m_cnt <= 0; m_st <= 1'b0; m_ht <= 1'b0;
      end else if (m_cnt == HZ - 1) begin
        m_cnt  <= 0;
        m_secs <= (m_secs + 1) % 86400;
        m_st   <= 1'b1;
        m_ht   <= ((m_secs + 1) % 3600 == 0);
      end else begin
        m_cnt <= m_cnt + 1; m_st <= 1'b0; m_ht <= 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [26:0] dut_vec, exp_vec;
  assign dut_vec = {H1, H0, M1, M0, S1, S0, sec_tick, hour_tick, load_err};
  assign exp_vec = {to_bcd(m_secs), m_st, m_ht, m_err};

  always @(negedge clk) begin
    if (chk_on) begin
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL model_cmp t=%0t got time=%h st=%b ht=%b err=%b expected time=%h st=%b ht=%b err=%b",
                 $time, dut_vec[26:3], dut_vec[2], dut_vec[1], dut_vec[0],
                 exp_vec[26:3], exp_vec[2], exp_vec[1], exp_vec[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_set(input logic [23:0] t);
    {set_h1, set_h0, set_m1, set_m0, set_s1, set_s0} = t;
  endtask

  task automatic do_load(input logic [23:0] t);
    drive_set(t);
    set_en = 1'b1;
    step(1);
    set_en = 1'b0;
    step(1);
  endtask

  task automatic check_lit(input string name, input logic [23:0] t,
                           input logic st, input logic ht, input logic err);
    checks++;
    if ({H1, H0, M1, M0, S1, S0, sec_tick, hour_tick, load_err} !== {t, st, ht, err}) begin
      errors++;
      $display("FAIL %s got time=%h st=%b ht=%b err=%b expected time=%h st=%b ht=%b err=%b",
               name, {H1, H0, M1, M0, S1, S0}, sec_tick, hour_tick, load_err,
               t, st, ht, err);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1;
    set_en = 1'b0;
    drive_set(24'h000000);
    step(1);
    chk_on = 1'b1;
    step(1);
    check_lit("reset_state", 24'h000000, 1'b0, 1'b0, 1'b0);

    // free run from reset
    rst = 1'b0;
    step(3);
    check_lit("run_no_tick_c3", 24'h000000, 1'b0, 1'b0, 1'b0);
    step(1);
    check_lit("run_tick_c4", 24'h000001, 1'b1, 1'b0, 1'b0);
    step(4);
    check_lit("run_tick_c8", 24'h000002, 1'b1, 1'b0, 1'b0);

    // midnight wrap
    do_load(24'h235958);
    check_lit("load_235958", 24'h235958, 1'b0, 1'b0, 1'b0);
    step(4);
    check_lit("to_235959", 24'h235959, 1'b1, 1'b0, 1'b0);
    step(4);
    check_lit("midnight", 24'h000000, 1'b1, 1'b1, 1'b0);

    // hour carries
    do_load(24'h095959);
    step(4);
    check_lit("to_100000", 24'h100000, 1'b1, 1'b1, 1'b0);
    do_load(24'h190959);
    step(4);
    check_lit("to_191000", 24'h191000, 1'b1, 1'b0, 1'b0);

    // rejection paths
    do_load(24'h123456);
    check_lit("load_123456", 24'h123456, 1'b0, 1'b0, 1'b0);
    do_load(24'h240000);
    check_lit("reject_24h", 24'h123456, 1'b0, 1'b0, 1'b1);
    do_load(24'h050607);
    check_lit("accept_050607", 24'h050607, 1'b0, 1'b0, 1'b0);
    do_load(24'h1A0000);
    check_lit("reject_h0_A", 24'h050607, 1'b0, 1'b0, 1'b1);
    do_load(24'h126000);
    check_lit("reject_60min", 24'h050607, 1'b0, 1'b0, 1'b1);

    // long setting hold, then drop where a run count would hit terminal
    set_en = 1'b1;
    step(20);
    check_lit("set_hold_frozen", 24'h050607, 1'b0, 1'b0, 1'b1);
    drive_set(24'h112233);
    step(3);
    set_en = 1'b0;
    step(1);
    check_lit("drop_load", 24'h112233, 1'b0, 1'b0, 1'b0);
    step(3);
    check_lit("drop_no_tick_yet", 24'h112233, 1'b0, 1'b0, 1'b0);
    step(1);
    check_lit("drop_first_tick", 24'h112234, 1'b1, 1'b0, 1'b0);

    // reset mid-second with set_en held through release
    do_load(24'h070809);
    do_load(24'h250000);
    check_lit("pre_rst_err", 24'h070809, 1'b0, 1'b0, 1'b1);
    step(2);
    set_en = 1'b1;
    rst = 1'b1;
    step(1);
    check_lit("rst_mid_second", 24'h000000, 1'b0, 1'b0, 1'b0);
    step(1);
    rst = 1'b0;
    drive_set(24'h131415);
    step(5);
    check_lit("rst_release_no_load", 24'h000000, 1'b0, 1'b0, 1'b0);
    set_en = 1'b0;
    step(1);
    check_lit("post_rst_load", 24'h131415, 1'b0, 1'b0, 1'b0);
    step(4);
    check_lit("post_rst_tick", 24'h131416, 1'b1, 1'b0, 1'b0);

    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
